// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: HH:MM:00 rising-edge match drives an armed/ringing/snooze FSM with ring timeout.
// Outputs are registered from next-state (1 CLK after trig); no backpressure, STOP/SNOOZE are single-cycle pulses.
module alarm_ring_ctrl #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int SNOOZE_MAX = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       ARM,
   input  logic       STOP,
   input  logic       SNOOZE,
   input  logic [3:0] CNT10,
   input  logic [2:0] CNT6,
   input  logic [3:0] CNT10M,
   input  logic [2:0] CNT6M,
   input  logic [3:0] CNT10T,
   input  logic [1:0] CNT3T,
   input  logic [3:0] AL_CNT10M,
   input  logic [2:0] AL_CNT6M,
   input  logic [3:0] AL_CNT10T,
   input  logic [1:0] AL_CNT3T,
   output logic       BUZZ_EN,
   output logic       LED,
   output logic [1:0] STATE,
   output logic [1:0] SNZ_LEFT
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_RINGING = 2'b10,
      S_SNOOZE  = 2'b11
   } state_t;

   localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
   localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
   localparam logic [1:0] SNZ_RELOAD  = 2'(SNOOZE_MAX);

   state_t     state_q, state_d;
   logic [7:0] ring_cnt, ring_cnt_d;
   logic [9:0] snz_cnt, snz_cnt_d;
   logic [1:0] snz_left, snz_left_d;
   logic       match, match_d, trig;
   logic       buzz_q, led_q;

   // Seconds must be :00 so a match fires once per minute boundary, not for the whole minute.
   assign match = (CNT10M == AL_CNT10M) && (CNT6M == AL_CNT6M) &&
                  (CNT10T == AL_CNT10T) && (CNT3T == AL_CNT3T) &&
                  (CNT10 == 4'd0) && (CNT6 == 3'd0);
   assign trig  = match & ~match_d;

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt;
      snz_cnt_d  = snz_cnt;
      snz_left_d = snz_left;
      case (state_q)
         S_IDLE: begin
            if (ARM) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!ARM) begin
               state_d = S_IDLE;
            end else if (trig) begin
               state_d    = S_RINGING;
               ring_cnt_d = 8'd0;
            end
         end
         S_RINGING: begin
            if (!ARM) begin
               state_d = S_IDLE;
            end else if (STOP) begin
               state_d = S_ARMED;
            end else if (SNOOZE && snz_left != 2'd0) begin
               state_d    = S_SNOOZE;
               snz_cnt_d  = 10'd0;
               snz_left_d = snz_left - 2'd1;
            end else if (ENABLE) begin
               if (ring_cnt == RING_LAST) state_d = S_ARMED;
               else                       ring_cnt_d = ring_cnt + 8'd1;
            end
         end
         S_SNOOZE: begin
            if (!ARM) begin
               state_d = S_IDLE;
            end else if (STOP) begin
               state_d = S_ARMED;
            end else if (ENABLE) begin
               if (snz_cnt == SNOOZE_LAST) begin
                  state_d    = S_RINGING;
                  ring_cnt_d = 8'd0;
               end else begin
                  snz_cnt_d = snz_cnt + 10'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A fresh alarm event always starts with the full snooze allowance.
      if (state_d == S_ARMED || state_d == S_IDLE) snz_left_d = SNZ_RELOAD;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         ring_cnt <= 8'd0;
         snz_cnt  <= 10'd0;
         snz_left <= SNZ_RELOAD;
         match_d  <= 1'b0;
         buzz_q   <= 1'b0;
         led_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ring_cnt <= ring_cnt_d;
         snz_cnt  <= snz_cnt_d;
         snz_left <= snz_left_d;
         match_d  <= match;
         buzz_q   <= (state_d == S_RINGING);
         led_q    <= (state_d != S_IDLE);
      end
   end

   assign BUZZ_EN  = buzz_q;
   assign LED      = led_q;
   assign STATE    = state_q;
   assign SNZ_LEFT = snz_left;

endmodule
